// File: rtl/rr_arb4_sel_if.sv
// Handshake bundle between the round-robin selector and its requesters/consumer.
// master = arbiter side (drives select/grant), slave = requester/consumer side.
interface rr_arb4_sel_if;
  logic [3:0] req;
  logic       ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic [3:0] hold_cnt;

  modport master (
    input  req,
    input  ready,
    output sel,
    output grant,
    output valid,
    output hold_cnt
  );

  modport slave (
    output req,
    output ready,
    input  sel,
    input  grant,
    input  valid,
    input  hold_cnt
  );
endinterface

// File: rtl/rr_arb4_sel.sv
// Four-source round-robin selector for a downstream 4:1 mux, with a bounded
// tenure of MAX_HOLD transfers per grant. All outputs come straight from flops.
module rr_arb4_sel #(
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb4_sel_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] hold_q, hold_d;
  logic       found;
  logic [1:0] winner;
  logic       xfer;
  logic       can_hold;

  // Search begins one past the last selection; the lowest offset is written
  // last so it wins. Offset 4 wraps back onto the last selection itself.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i) + 2'd1;
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  always_comb begin
    {found, winner} = rr_pick(bus.req, sel_q);
  end

  assign xfer     = (state_q == GRANT) && bus.ready;
  assign can_hold = bus.req[sel_q] && (({1'b0, hold_q} + 5'd1) < 5'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        hold_d  = 4'd0;
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = onehot(winner);
        end
      end
      GRANT: begin
        // Without a transfer the grant is frozen, whatever req does.
        if (xfer) begin
          if (can_hold) begin
            hold_d = hold_q + 4'd1;
          end else if (found) begin
            sel_d   = winner;
            grant_d = onehot(winner);
            hold_d  = 4'd0;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            hold_d  = 4'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        hold_d  = 4'd0;
      end
    endcase
  end

  // sel resets to 3 so that source 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b11;
      grant_q <= 4'b0000;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.grant    = grant_q;
  assign bus.valid    = (state_q == GRANT);
  assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Bench for rr_arb4_sel: three instances (MAX_HOLD = 1, 4, 2) share stimulus;
// a reference model feeds a scoreboard and directed sequences pin key cases.
module tb_rr_arb4_sel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arb4_sel_if ia ();
  rr_arb4_sel_if ib ();
  rr_arb4_sel_if ic ();

  rr_arb4_sel #(.MAX_HOLD(1)) u_mh1 (.clk(clk), .rst(rst), .bus(ia.master));
  rr_arb4_sel #(.MAX_HOLD(4)) u_mh4 (.clk(clk), .rst(rst), .bus(ib.master));
  rr_arb4_sel #(.MAX_HOLD(2)) u_mh2 (.clk(clk), .rst(rst), .bus(ic.master));

  logic [1:0] o_sel[3];
  logic [3:0] o_grant[3];
  logic       o_valid[3];
  logic [3:0] o_hold[3];

  assign o_sel[0] = ia.sel;  assign o_grant[0] = ia.grant;  assign o_valid[0] = ia.valid;  assign o_hold[0] = ia.hold_cnt;
  assign o_sel[1] = ib.sel;  assign o_grant[1] = ib.grant;  assign o_valid[1] = ib.valid;  assign o_hold[1] = ib.hold_cnt;
  assign o_sel[2] = ic.sel;  assign o_grant[2] = ic.grant;  assign o_valid[2] = ic.valid;  assign o_hold[2] = ic.hold_cnt;

  typedef struct packed {
    logic [1:0] inst;
    logic       v;
    logic [1:0] s;
    logic [3:0] g;
    logic [3:0] h;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, one slot per instance.
  int m_st[3];
  int m_sel[3];
  int m_hold[3];

  function automatic int mh(input int k);
    case (k)
      0: return 1;
      1: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++) begin
      if (r[(last + off) % 4]) return (last + off) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic r, input logic [3:0] rq, input logic rd);
    int w;
    w = pick(rq, m_sel[k]);
    if (r) begin
      m_st[k] = 0; m_sel[k] = 3; m_hold[k] = 0;
    end else if (m_st[k] == 0) begin
      if (w >= 0) begin
        m_st[k] = 1; m_sel[k] = w; m_hold[k] = 0;
      end
    end else if (rd) begin
      if (rq[m_sel[k]] && (m_hold[k] + 1 < mh(k))) begin
        m_hold[k] = m_hold[k] + 1;
      end else if (w >= 0) begin
        m_sel[k] = w; m_hold[k] = 0;
      end else begin
        m_st[k] = 0; m_hold[k] = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] rq, input logic rd);
    exp_t e;
    @(negedge clk);
    rst = r;
    ia.req = rq; ia.ready = rd;
    ib.req = rq; ib.ready = rd;
    ic.req = rq; ic.ready = rd;
    for (int k = 0; k < 3; k++) begin
      model_step(k, r, rq, rd);
      e.inst = 2'(k);
      e.v    = (m_st[k] == 1);
      e.s    = 2'(m_sel[k]);
      e.g    = (m_st[k] == 1) ? (4'b0001 << m_sel[k]) : 4'b0000;
      e.h    = 4'(m_hold[k]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      int k;
      e = sb.pop_front();
      k = int'(e.inst);
      chk($sformatf("sb_valid[%0d]", k), int'(o_valid[k]), int'(e.v));
      chk($sformatf("sb_sel[%0d]", k),   int'(o_sel[k]),   int'(e.s));
      chk($sformatf("sb_grant[%0d]", k), int'(o_grant[k]), int'(e.g));
      chk($sformatf("sb_hold[%0d]", k),  int'(o_hold[k]),  int'(e.h));
      chk($sformatf("inv_grant[%0d]", k), int'(o_grant[k]),
          o_valid[k] ? int'(4'b0001 << o_sel[k]) : 0);
      chk($sformatf("inv_hold_lt_max[%0d]", k), int'(o_hold[k]) < mh(k) ? 1 : 0, 1);
    end
  endtask

  task automatic dchk(input string tag, input int k, input int s, input int h, input int v);
    chk({tag, "_sel"},   int'(o_sel[k]),   s);
    chk({tag, "_hold"},  int'(o_hold[k]),  h);
    chk({tag, "_valid"}, int'(o_valid[k]), v);
  endtask

  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_bs[9] = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
  int seq_bh[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_sel[k] = 3; m_hold[k] = 0;
    end
    ia.req = 4'b0; ia.ready = 1'b0;
    ib.req = 4'b0; ib.ready = 1'b0;
    ic.req = 4'b0; ic.ready = 1'b0;

    // Reset state, with requests present that must be ignored.
    cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0);
    dchk("reset", 0, 3, 0, 0);
    chk("reset_grant", int'(o_grant[1]), 0);
    cycle(1'b0, 4'b0000, 1'b0);
    dchk("idle_noreq", 1, 3, 0, 0);

    // MAX_HOLD=1 rotation on full request.
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b1111, 1'b1);
      dchk($sformatf("rot_mh1_%0d", i), 0, seq_a[i], 0, 1);
    end

    // MAX_HOLD=4 alternating between sources 0 and 2.
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 4'b0101, 1'b1);
      dchk($sformatf("hold_mh4_%0d", i), 1, seq_bs[i], seq_bh[i], 1);
    end

    // Grant frozen while the consumer stalls and the request drops.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    dchk("stall_grant", 1, 2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0000, 1'b0);
      dchk($sformatf("stall_%0d", i), 1, 2, 0, 1);
    end
    cycle(1'b0, 4'b0000, 1'b1);
    dchk("stall_release", 1, 2, 0, 0);
    chk("stall_release_grant", int'(o_grant[1]), 0);

    // Single requester re-granted to itself at tenure expiry.
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'b0010, 1'b1);
      dchk($sformatf("self_mh2_%0d", i), 2, 1, i % 2, 1);
    end

    // Reset in the middle of a tenure discards the grant.
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, 1'b1);
    dchk("mid_tenure", 1, 2, 2, 1);
    cycle(1'b1, 4'b1111, 1'b1);
    dchk("mid_rst", 1, 3, 0, 0);
    chk("mid_rst_grant", int'(o_grant[1]), 0);
    cycle(1'b0, 4'b1111, 1'b1);
    dchk("post_rst", 1, 0, 0, 1);

    // Random traffic, checked against the model only.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
